// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   div_state_e   : FSM state encoding (IDLE, CALC, FIX, DONE)
//   STATE_W       : width of the state encoding
//   DBZ_QUOT_BIT  : fill bit for the quotient on divide-by-zero (all ones)
//   DBZ_FLAG      : value of div_by_zero when the divisor was zero
package div_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic DBZ_QUOT_BIT = 1'b1;
  localparam logic DBZ_FLAG     = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration (combinational).
//   rem      : partial remainder, WIDTH+1 bits
//   dq       : dividend bits still to be shifted in / quotient bits produced
//   div      : divisor magnitude, WIDTH+1 bits
//   rem_next : partial remainder after this step
//   dq_next  : dq shifted left with the new quotient bit in bit 0
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] dq,
  input  logic [WIDTH:0]   div,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] dq_next
);

  logic [WIDTH:0] shifted;

  always_comb begin
    // The partial remainder is always below the divisor, so its top bit is
    // zero and dropping it during the shift loses nothing.
    shifted = {rem[WIDTH-1:0], dq[WIDTH-1]};
    if (shifted >= div) begin
      rem_next = shifted - div;
      dq_next  = {dq[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted;
      dq_next  = {dq[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider, one quotient bit per clock.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   in_valid/ready : operand handshake; a transfer happens on a rising edge
//                    where both are high. in_ready is high only in IDLE.
//   dividend, divisor, is_signed : operands (is_signed honoured if SIGNED_EN)
//   out_valid/ready: result handshake; out_valid holds with stable results
//                    until a rising edge where out_ready is also high.
//   quotient, remainder, div_by_zero : registered results
//   state_dbg      : current FSM state
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output div_state_e       state_dbg
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH:0]   ONE_X    = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   rem_acc_q, rem_acc_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH:0]   div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic             dbz_q, dbz_d;

  logic             signed_op, a_neg, b_neg;
  logic [WIDTH:0]   a_mag, b_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_dq;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_acc_q),
    .dq       (dq_q),
    .div      (div_q),
    .rem_next (step_rem),
    .dq_next  (step_dq)
  );

  // Magnitudes are WIDTH+1 bits so that |MIN| is representable.
  always_comb begin
    signed_op = (SIGNED_EN != 0) && is_signed;
    a_neg     = signed_op && dividend[WIDTH-1];
    b_neg     = signed_op && divisor[WIDTH-1];
    a_mag     = a_neg ? ({1'b0, ~dividend} + ONE_X) : {1'b0, dividend};
    b_mag     = b_neg ? ({1'b0, ~divisor} + ONE_X) : {1'b0, divisor};
  end

  always_comb begin
    state_d    = state_q;
    rem_acc_d  = rem_acc_q;
    dq_d       = dq_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    res_rem_d  = res_rem_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_acc_d  = '0;
          dq_d       = a_mag[WIDTH-1:0];
          div_d      = b_mag;
          cnt_d      = CNT_LOAD;
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          if (divisor == '0) begin
            // Zero divisor bypasses the iterations entirely.
            quot_d    = {WIDTH{DBZ_QUOT_BIT}};
            res_rem_d = dividend;
            dbz_d     = DBZ_FLAG;
            state_d   = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_acc_d = step_rem;
        dq_d      = step_dq;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quot_d    = neg_quot_q ? (~dq_q + ONE_W) : dq_q;
        res_rem_d = neg_rem_q ? (~rem_acc_q[WIDTH-1:0] + ONE_W)
                              : rem_acc_q[WIDTH-1:0];
        dbz_d     = 1'b0;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_acc_q  <= '0;
      dq_q       <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      res_rem_q  <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_acc_q  <= rem_acc_d;
      dq_q       <= dq_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      res_rem_q  <= res_rem_d;
      dbz_q      <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = res_rem_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and table-driven bench for seq_divider (WIDTH 8 and WIDTH 16).
module tb_seq_divider;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       iv8, ir8, s8, ov8, or8, z8;
  logic [7:0] a8, b8, q8, r8;
  div_state_e st8;

  // WIDTH=16 instance
  logic        iv16, ir16, s16, ov16, or16, z16;
  logic [15:0] a16, b16, q16, r16;
  div_state_e  st16;

  seq_divider #(.WIDTH(8), .SIGNED_EN(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .dividend(a8), .divisor(b8), .is_signed(s8), .out_valid(ov8),
    .out_ready(or8), .quotient(q8), .remainder(r8), .div_by_zero(z8),
    .state_dbg(st8)
  );

  seq_divider #(.WIDTH(16), .SIGNED_EN(1)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .dividend(a16), .divisor(b16), .is_signed(s16), .out_valid(ov16),
    .out_ready(or16), .quotient(q16), .remainder(r16), .div_by_zero(z16),
    .state_dbg(st16)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout waiting on DUT", nm);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic hold, output logic [7:0] q, output logic [7:0] r,
                     output logic z, output int lat);
    int t = 0;
    while (!ir8 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (!ir8) timeout("in_ready8");
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1; or8 = hold;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ov8 && lat < 100);
    if (!ov8) timeout("out_valid8");
    q = q8; r = r8; z = z8;
  endtask

  task automatic ack8(input string nm);
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk({nm, "_ov_drop"}, ov8, 0);
    chk({nm, "_ir_back"}, ir8, 1);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      output logic [15:0] q, output logic [15:0] r,
                      output logic z, output int lat);
    int t = 0;
    while (!ir16 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (!ir16) timeout("in_ready16");
    a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ov16 && lat < 100);
    if (!ov16) timeout("out_valid16");
    q = q16; r = r16; z = z16;
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    chk("w16_ir_back", ir16, 1);
  endtask

  initial begin
    logic [7:0]  q, r;
    logic [15:0] qq, rr, ea, eb, eq, er;
    logic        z, es, ez;
    int          lat, sa, sb, qi, ri;

    vecs[0]  = '{8'd200, 8'd7,   1'b0, 8'd28,  8'd4,   1'b0, 9};
    vecs[1]  = '{8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF,  1'b0, 9};  // -7/2
    vecs[2]  = '{8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01,  1'b0, 9};  // 7/-2
    vecs[3]  = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0, 9};  // MIN/-1
    vecs[4]  = '{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0, 9};
    vecs[5]  = '{8'd45,  8'd0,   1'b0, 8'hFF,  8'd45,  1'b1, 1};
    vecs[6]  = '{8'd45,  8'd0,   1'b1, 8'hFF,  8'd45,  1'b1, 1};
    vecs[7]  = '{8'hD3,  8'h00,  1'b1, 8'hFF,  8'hD3,  1'b1, 1};  // -45/0
    vecs[8]  = '{8'd3,   8'd10,  1'b0, 8'd0,   8'd3,   1'b0, 9};
    vecs[9]  = '{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0, 9};
    vecs[10] = '{8'h80,  8'h07,  1'b1, 8'hEE,  8'hFE,  1'b0, 9};  // -128/7
    vecs[11] = '{8'h80,  8'h07,  1'b0, 8'h12,  8'h02,  1'b0, 9};  // 128/7
    vecs[12] = '{8'hF9,  8'h02,  1'b0, 8'h7C,  8'h01,  1'b0, 9};  // 249/2
    vecs[13] = '{8'hF9,  8'hFE,  1'b1, 8'h03,  8'hFF,  1'b0, 9};  // -7/-2

    rst_n = 1'b0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; s8 = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0; s16 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ir", ir8, 1);
    chk("rst_ov", ov8, 0);
    chk("rst_q", q8, 0);
    chk("rst_r", r8, 0);
    chk("rst_dbz", z8, 0);
    chk("rst_ov16", ov16, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 14; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, q, r, z, lat);
      chk($sformatf("v%0d_q", i), q, vecs[i].q);
      chk($sformatf("v%0d_r", i), r, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), z, vecs[i].z);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      ack8($sformatf("v%0d", i));
    end

    // out_ready already high before out_valid: result still presented,
    // in_ready returns one cycle later.
    op8(8'd100, 8'd9, 1'b0, 1'b1, q, r, z, lat);
    chk("early_rdy_q", q, 8'd11);
    chk("early_rdy_lat", lat, 9);
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("early_rdy_ir", ir8, 1);
    chk("early_rdy_ov", ov8, 0);

    // Backpressure with ignored in_valid while busy
    op8(8'd200, 8'd7, 1'b0, 1'b0, q, r, z, lat);
    iv8 = 1'b1; a8 = 8'd1; b8 = 8'd1; s8 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_ov", ov8, 1);
      chk("bp_ir", ir8, 0);
      chk("bp_q", q8, 8'd28);
      chk("bp_r", r8, 8'd4);
    end
    iv8 = 1'b0;
    ack8("bp");
    op8(8'd45, 8'd0, 1'b0, 1'b0, q, r, z, lat);
    chk("bp_next_q", q, 8'hFF);
    chk("bp_next_r", r, 8'd45);
    chk("bp_next_dbz", z, 1);
    chk("bp_next_lat", lat, 1);
    ack8("bp_next");

    // Reset in the middle of CALC
    a8 = 8'd200; b8 = 8'd7; s8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_state", st8, CALC);
    rst_n = 1'b0;
    #1;
    chk("midrst_ov", ov8, 0);
    chk("midrst_ir", ir8, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_rel_ir", ir8, 1);
    chk("midrst_rel_state", st8, IDLE);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_result", ov8, 0);
    op8(8'd100, 8'd9, 1'b0, 1'b0, q, r, z, lat);
    chk("after_rst_q", q, 8'd11);
    chk("after_rst_r", r, 8'd1);
    chk("after_rst_lat", lat, 9);
    ack8("after_rst");

    // WIDTH=16 sweep against integer reference
    for (int i = 0; i < 24; i++) begin
      ea = 16'($urandom_range(0, 65535));
      eb = 16'($urandom_range(0, 65535));
      es = 1'($urandom_range(0, 1));
      if (i % 8 == 0) eb = 16'd0;
      if (i == 1) begin ea = 16'h8000; eb = 16'hFFFF; es = 1'b1; end
      if (i == 2) begin ea = 16'd5; eb = 16'd40000; es = 1'b0; end
      if (eb == 16'd0) begin
        eq = 16'hFFFF; er = ea; ez = 1'b1;
      end else if (es) begin
        sa = int'($signed(ea));
        sb = int'($signed(eb));
        qi = sa / sb;
        ri = sa % sb;
        eq = qi[15:0]; er = ri[15:0]; ez = 1'b0;
      end else begin
        eq = ea / eb; er = ea % eb; ez = 1'b0;
      end
      op16(ea, eb, es, qq, rr, z, lat);
      chk($sformatf("w16_%0d_q", i), qq, eq);
      chk($sformatf("w16_%0d_r", i), rr, er);
      chk($sformatf("w16_%0d_dbz", i), z, ez);
      chk($sformatf("w16_%0d_lat", i), lat, ez ? 1 : 17);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
